uart_rx: RTL
============

# uart_rx

Serial receiver for the lab UART: recovers 8N1 frames from the asynchronous `rx` line using the same oversampled baud `tick` that drives the transmitter. It synchronises the line, rejects start-bit glitches, samples each bit at mid-period, and presents the received byte with a one-cycle completion pulse and a framing-error flag. It sits between the board RX pin and the byte-level consumer (FIFO or loopback logic).

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `OS`, 16: ticks per bit period; must be even, ≥4.
- `SB_TICK`, 16: ticks spent sampling the stop bit (16 = 1 stop bit).
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-`clk` pulse at OS× baud rate.
- `rx`  in  1  asynchronous serial input, idle high.
- `dout`  out  DBIT  last received byte; held until the next frame completes.
- `rx_done_tick`  out  1  one-`clk` pulse when a frame finishes.
- `frame_err`  out  1  stop-bit status of the last frame; valid when `rx_done_tick` is high, held until the next completion.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`, reset to 1); all decisions use `rx_s`.
- Internal state: tick counter `s` (log2(max(OS,SB_TICK)) bits), bit counter `n` (log2(DBIT) bits), shift register `b` (DBIT bits).
- States: IDLE, START, DATA, STOP, WAIT_HIGH. Counters advance only on cycles with `tick`=1.
- IDLE: when `rx_s`=0, go to START with `s`=0. No tick is required to leave IDLE.
- START: on each tick, if `s`==OS/2−1, check `rx_s`:
  - If 0, go to DATA with `s`=0, `n`=0.
  - If 1, treat it as a glitch and return to IDLE with no output.
  - Otherwise `s`++.
- DATA: on each tick, if `s`==OS−1, set `b`={`rx_s`,`b`[DBIT−1:1]} and `s`=0. If `n`==DBIT−1, go to STOP; else `n`++. Otherwise `s`++.
- STOP: on each tick, if `s`==SB_TICK−1:
  - Load `dout`←`b`, set `frame_err`←~`rx_s`, pulse `rx_done_tick`.
  - If `rx_s`=1, go to IDLE; else go to WAIT_HIGH.
  - Otherwise `s`++.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition (line held low) from retriggering frames.
- `dout` and `frame_err` change only at frame completion.

## Timing
- Reset (`rst_n`=0 at posedge):
  - state IDLE; `s`, `n`, `b` = 0.
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `busy`=0, `rx_s`=1.
- Reset mid-frame aborts the frame with no `rx_done_tick`. `rst_n` takes priority over `tick`.
- Synchroniser latency: 2 `clk` from `rx` edge to `rx_s`. IDLE→START occurs 1 `clk` later.
- Sample points: start bit at tick OS/2 after detection; data bit k at OS/2 + (k+1)·OS ticks; stop bit at OS/2 + DBIT·OS + SB_TICK ticks.
- Completion: `rx_done_tick` is registered and high for exactly one `clk`, the cycle after the sampling tick. `dout` and `frame_err` are valid in that same cycle.
- `tick` arriving while IDLE has no effect. A falling edge arriving in the same cycle as completion is seen in IDLE on the next cycle, so back-to-back frames are received without loss.
- `tick` held high every clock is legal; the block then runs OS clocks per bit.

## Test plan
- Reset, then drive `rx`=1 for 100 ticks → `dout`=0x00, `rx_done_tick` never pulses, `busy`=0.
- Send 0x55, then 0xA3, then 0x00, each 8N1 at OS=16 → three `rx_done_tick` pulses with `dout`=0x55, 0xA3, 0x00 respectively and `frame_err`=0 each time. `dout` is stable between pulses.
- Send back-to-back 0xFF,0x01 with zero idle gap → two pulses carrying 0xFF then 0x01.
- Drive a low glitch of 4 ticks on `rx` → return to IDLE, no pulse, `busy` low again within 8 ticks of the glitch start.
- Send 0x3C with stop bit 0, then hold `rx` low for 40 ticks, then high → exactly one pulse with `dout`=0x3C, `frame_err`=1. `busy` stays high until `rx` returns high, with no further pulse. A following 0x7E is then received with `frame_err`=0.
- Assert `rst_n`=0 during data bit 4 of a frame → outputs return to reset values, no pulse for that frame. The next full 0x96 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling on an oversampled tick, and break (line-held-low) lockout.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);
    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_meta_q, rx_s_q;
    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        // a line that is high again at mid start bit was only a glitch
                        state_d = rx_s_q ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT) begin
                        b_d     = {rx_s_q, b_q[DBIT-1:1]};
                        s_d     = '0;
                        state_d = (n_q == N_LAST) ? STOP : DATA;
                        n_d     = (n_q == N_LAST) ? n_q : n_q + NW'(1);
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
                        state_d = rx_s_q ? IDLE : WAIT_HIGH;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            WAIT_HIGH: state_d = rx_s_q ? IDLE : WAIT_HIGH;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
endmodule
